// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared PTE/SDR1 field positions, walker states and match helper
// Optional feature macro: MMU_PTW_RC_UPDATE_EN (adds the ST_RC state).
package mmu_pkg;

    // PTE word0 fields
    localparam int PTE_V       = 31;
    localparam int PTE_VSID_HI = 30;
    localparam int PTE_VSID_LO = 7;
    localparam int PTE_H       = 6;
    localparam int PTE_API_HI  = 5;
    localparam int PTE_API_LO  = 0;

    // PTE word1 fields
    localparam int PTE_RPN_HI  = 31;
    localparam int PTE_RPN_LO  = 12;
    localparam int PTE_R       = 8;
    localparam int PTE_C       = 7;
    localparam int PTE_WIMG_HI = 6;
    localparam int PTE_WIMG_LO = 3;
    localparam int PTE_WIMG_I  = 5;
    localparam int PTE_PP_HI   = 1;
    localparam int PTE_PP_LO   = 0;

    // SDR1 fields
    localparam int SDR1_ORG_HI  = 31;
    localparam int SDR1_ORG_LO  = 16;
    localparam int SDR1_MASK_HI = 8;
    localparam int SDR1_MASK_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HASH  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_LOAD  = 3'd5,
`ifdef MMU_PTW_RC_UPDATE_EN
        ST_FAULT = 3'd6,
        ST_RC    = 3'd7
`else
        ST_FAULT = 3'd6
`endif
    } ptw_state_e;

    // A PTE matches when valid, VSID and hash-select agree, and the
    // abbreviated page index equals EA[27:22].
    function automatic logic pte_match(input logic [31:0] word0,
                                       input logic [23:0] vsid,
                                       input logic        sec,
                                       input logic [5:0]  api);
        return word0[PTE_V]
            && (word0[PTE_VSID_HI:PTE_VSID_LO] == vsid)
            && (word0[PTE_H] == sec)
            && (word0[PTE_API_HI:PTE_API_LO] == api);
    endfunction

endpackage

// File: rtl/mmu_ptw_hash.sv
// rtl/mmu_ptw_hash.sv - combinational HTAB hash to PTEG byte address
// Ports: vsid_i (VSID[18:0]), ea_i (EA page index [27:12]), sec_i (1 = secondary hash),
//        org_i (HTABORG), mask_i (HTABMASK), pteg_addr_o (64-byte aligned PTEG address).
module mmu_ptw_hash (
    input  logic [18:0] vsid_i,
    input  logic [27:12] ea_i,
    input  logic        sec_i,
    input  logic [15:0] org_i,
    input  logic [8:0]  mask_i,
    output logic [31:0] pteg_addr_o
);

    logic [18:0] h1;
    logic [18:0] h;

    assign h1 = vsid_i ^ {3'b000, ea_i};
    assign h  = sec_i ? ~h1 : h1;

    // The upper hash bits only select within the table when the mask allows it.
    assign pteg_addr_o = {org_i[15:9], org_i[8:0] | (h[18:10] & mask_i), h[9:0], 6'b000000};

endmodule

// File: rtl/mmu_ptw.sv
// rtl/mmu_ptw.sv - PPC32 hashed page-table walker refilling the TLB on a miss
// Ports: clk_i/reset_i (sync active-low); req_i + req_ea/vsid/ks/kp_i walk request;
//        sdr1_i table base/mask; abort_i cancel; busy_o/done_o/fault_o status;
//        mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i 64-bit PTE read port;
//        tlb_load_o + tlb_new_*_o TLB entry load interface.
// Optional macro MMU_PTW_RC_UPDATE_EN adds mem_we_o/mem_wdata_o and sets PTE.R on hit.
module mmu_ptw
    import mmu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [31:0] req_ea_i,
    input  logic [23:0] req_vsid_i,
    input  logic        req_ks_i,
    input  logic        req_kp_i,
    input  logic [31:0] sdr1_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
`ifdef MMU_PTW_RC_UPDATE_EN
    output logic        mem_we_o,
    output logic [63:0] mem_wdata_o,
`endif
    output logic        tlb_load_o,
    output logic [31:0] tlb_new_ea_o,
    output logic [31:0] tlb_new_pa_o,
    output logic [1:0]  tlb_new_pp_o,
    output logic        tlb_new_ks_o,
    output logic        tlb_new_kp_o,
    output logic        tlb_new_cacheable_o
);

    ptw_state_e  state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic        sec_q, sec_d;
    logic        abort_pend_q, abort_pend_d;
    logic [31:12] ea_q, ea_d;
    logic [23:0] vsid_q, vsid_d;
    logic        ks_q, ks_d;
    logic        kp_q, kp_d;
    logic [15:0] org_q, org_d;
    logic [8:0]  mask_q, mask_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;

    logic [31:0] tlb_ea_q, tlb_ea_d;
    logic [31:0] tlb_pa_q, tlb_pa_d;
    logic [1:0]  tlb_pp_q, tlb_pp_d;
    logic        tlb_ks_q, tlb_ks_d;
    logic        tlb_kp_q, tlb_kp_d;
    logic        tlb_cach_q, tlb_cach_d;

    logic [31:0] pteg_addr;
    logic [31:0] pte_addr;
    logic        hit;

    mmu_ptw_hash u_hash (
        .vsid_i      (vsid_q[18:0]),
        .ea_i        (ea_q[27:12]),
        .sec_i       (sec_q),
        .org_i       (org_q),
        .mask_i      (mask_q),
        .pteg_addr_o (pteg_addr)
    );

    assign pte_addr = pteg_addr | {26'd0, slot_q, 3'b000};
    assign hit      = pte_match(word0_q, vsid_q, sec_q, ea_q[27:22]);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        sec_d        = sec_q;
        abort_pend_d = abort_pend_q;
        ea_d         = ea_q;
        vsid_d       = vsid_q;
        ks_d         = ks_q;
        kp_d         = kp_q;
        org_d        = org_q;
        mask_d       = mask_q;
        word0_d      = word0_q;
        word1_d      = word1_q;
        tlb_ea_d     = tlb_ea_q;
        tlb_pa_d     = tlb_pa_q;
        tlb_pp_d     = tlb_pp_q;
        tlb_ks_d     = tlb_ks_q;
        tlb_kp_d     = tlb_kp_q;
        tlb_cach_d   = tlb_cach_q;
        busy_o       = (state_q != ST_IDLE);
        done_o       = 1'b0;
        fault_o      = 1'b0;
        tlb_load_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = 32'd0;
`ifdef MMU_PTW_RC_UPDATE_EN
        mem_we_o     = 1'b0;
        mem_wdata_o  = 64'd0;
`endif

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (req_i) begin
                    ea_d    = req_ea_i[31:12];
                    vsid_d  = req_vsid_i;
                    ks_d    = req_ks_i;
                    kp_d    = req_kp_i;
                    org_d   = sdr1_i[SDR1_ORG_HI:SDR1_ORG_LO];
                    mask_d  = sdr1_i[SDR1_MASK_HI:SDR1_MASK_LO];
                    state_d = ST_HASH;
                end
            end
            ST_HASH: begin
                slot_d  = 3'd0;
                sec_d   = 1'b0;
                state_d = abort_i ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pte_addr;
                state_d    = abort_i ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // The read cannot be withdrawn once waiting, so an abort is
                // remembered and honoured when the ack arrives.
                mem_req_o  = 1'b1;
                mem_addr_o = pte_addr;
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    word0_d = mem_rdata_i[63:32];
                    word1_d = mem_rdata_i[31:0];
                    state_d = (abort_i || abort_pend_q) ? ST_IDLE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
`ifdef MMU_PTW_RC_UPDATE_EN
                    state_d = word1_q[PTE_R] ? ST_LOAD : ST_RC;
`else
                    state_d = ST_LOAD;
`endif
                end else if (slot_q == 3'd7) begin
                    if (!sec_q) begin
                        sec_d   = 1'b1;
                        slot_d  = 3'd0;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = ST_FETCH;
                end
            end
`ifdef MMU_PTW_RC_UPDATE_EN
            ST_RC: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = pte_addr;
                mem_wdata_o = {word0_q, word1_q | 32'h0000_0100};
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = (abort_i || abort_pend_q) ? ST_IDLE : ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                done_o     = 1'b1;
                tlb_load_o = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                fault_o = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TLB fields change only on the way into LOAD so they stay stable
        // between loads, including across aborted walks.
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            tlb_ea_d   = {ea_q, 12'h000};
            tlb_pa_d   = {word1_q[PTE_RPN_HI:PTE_RPN_LO], 12'h000};
            tlb_pp_d   = word1_q[PTE_PP_HI:PTE_PP_LO];
            tlb_ks_d   = ks_q;
            tlb_kp_d   = kp_q;
            tlb_cach_d = ~word1_q[PTE_WIMG_I];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            slot_q       <= 3'd0;
            sec_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            ea_q         <= '0;
            vsid_q       <= '0;
            ks_q         <= 1'b0;
            kp_q         <= 1'b0;
            org_q        <= '0;
            mask_q       <= '0;
            word0_q      <= '0;
            word1_q      <= '0;
            tlb_ea_q     <= '0;
            tlb_pa_q     <= '0;
            tlb_pp_q     <= '0;
            tlb_ks_q     <= 1'b0;
            tlb_kp_q     <= 1'b0;
            tlb_cach_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sec_q        <= sec_d;
            abort_pend_q <= abort_pend_d;
            ea_q         <= ea_d;
            vsid_q       <= vsid_d;
            ks_q         <= ks_d;
            kp_q         <= kp_d;
            org_q        <= org_d;
            mask_q       <= mask_d;
            word0_q      <= word0_d;
            word1_q      <= word1_d;
            tlb_ea_q     <= tlb_ea_d;
            tlb_pa_q     <= tlb_pa_d;
            tlb_pp_q     <= tlb_pp_d;
            tlb_ks_q     <= tlb_ks_d;
            tlb_kp_q     <= tlb_kp_d;
            tlb_cach_q   <= tlb_cach_d;
        end
    end

    assign tlb_new_ea_o        = tlb_ea_q;
    assign tlb_new_pa_o        = tlb_pa_q;
    assign tlb_new_pp_o        = tlb_pp_q;
    assign tlb_new_ks_o        = tlb_ks_q;
    assign tlb_new_kp_o        = tlb_kp_q;
    assign tlb_new_cacheable_o = tlb_cach_q;

    // The walker keeps a single read in flight: an ack is only legal
    // against the request currently presented.
    assert property (@(posedge clk_i) disable iff (!reset_i)
        mem_ack_i |-> (mem_req_o && (MAX_OUTSTANDING == 1)));

    // Fields of SDR1 and PTE word1 that the walker does not interpret.
`ifdef MMU_PTW_RC_UPDATE_EN
    logic unused_bits;
    assign unused_bits = ^{sdr1_i[15:9]};
`else
    logic unused_bits;
    assign unused_bits = ^{sdr1_i[15:9], word1_q[11:6], word1_q[4:2]};
`endif

endmodule

// File: tb/tb_mmu_ptw.sv
// tb/tb_mmu_ptw.sv - directed self-checking bench for mmu_ptw
module tb_mmu_ptw;

    logic        clk;
    logic        reset;
    logic        req;
    logic [31:0] req_ea;
    logic [23:0] req_vsid;
    logic        req_ks;
    logic        req_kp;
    logic [31:0] sdr1;
    logic        abort;
    logic        busy;
    logic        done;
    logic        fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        tlb_load;
    logic [31:0] tlb_new_ea;
    logic [31:0] tlb_new_pa;
    logic [1:0]  tlb_new_pp;
    logic        tlb_new_ks;
    logic        tlb_new_kp;
    logic        tlb_new_cacheable;
    logic        mem_we;
    logic [63:0] mem_wdata;

    mmu_ptw #(.MAX_OUTSTANDING(1)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .req_i               (req),
        .req_ea_i            (req_ea),
        .req_vsid_i          (req_vsid),
        .req_ks_i            (req_ks),
        .req_kp_i            (req_kp),
        .sdr1_i              (sdr1),
        .abort_i             (abort),
        .busy_o              (busy),
        .done_o              (done),
        .fault_o             (fault),
        .mem_req_o           (mem_req),
        .mem_addr_o          (mem_addr),
        .mem_ack_i           (mem_ack),
        .mem_rdata_i         (mem_rdata),
`ifdef MMU_PTW_RC_UPDATE_EN
        .mem_we_o            (mem_we),
        .mem_wdata_o         (mem_wdata),
`endif
        .tlb_load_o          (tlb_load),
        .tlb_new_ea_o        (tlb_new_ea),
        .tlb_new_pa_o        (tlb_new_pa),
        .tlb_new_pp_o        (tlb_new_pp),
        .tlb_new_ks_o        (tlb_new_ks),
        .tlb_new_kp_o        (tlb_new_kp),
        .tlb_new_cacheable_o (tlb_new_cacheable)
    );

`ifndef MMU_PTW_RC_UPDATE_EN
    assign mem_we    = 1'b0;
    assign mem_wdata = 64'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model and output monitor, both evaluated on the falling edge.
    logic [63:0] mem [int unsigned];
    int          lat = 1;
    int          wcnt = 0;
    int          cyc = 0;
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr_log [$];
    logic [63:0] wr_data_log [$];
    int          load_cnt, done_cnt, fault_cnt;
    int          load_cyc, wr_cyc, fault_cyc;
    logic        busy_after_fault;
    logic [31:0] cap_ea, cap_pa;
    logic [1:0]  cap_pp;
    logic        cap_ks, cap_kp, cap_cach;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            wcnt    = 0;
            mem_ack = 1'b0;
        end else if (mem_req && !mem_ack) begin
            wcnt++;
            if (wcnt > lat) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_we) begin
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                    mem[mem_addr] = mem_wdata;
                    wr_cyc = cyc;
                end else begin
                    rd_log.push_back(mem_addr);
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
                end
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        if (cyc == fault_cyc + 1) busy_after_fault = busy;
        if (tlb_load) begin
            load_cnt++;
            load_cyc = cyc;
            cap_ea   = tlb_new_ea;
            cap_pa   = tlb_new_pa;
            cap_pp   = tlb_new_pp;
            cap_ks   = tlb_new_ks;
            cap_kp   = tlb_new_kp;
            cap_cach = tlb_new_cacheable;
        end
        if (done) done_cnt++;
        if (fault) begin
            fault_cnt++;
            fault_cyc = cyc;
        end
    end

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        load_cnt = 0; done_cnt = 0; fault_cnt = 0;
        load_cyc = 0; wr_cyc = 0; fault_cyc = -10;
        busy_after_fault = 1'b1;
    endtask

    int start_cyc;

    task automatic start_walk(input logic with_abort);
        @(negedge clk); #1;
        req       = 1'b1;
        abort     = with_abort;
        start_cyc = cyc;
        @(negedge clk); #1;
        req   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        check_val(tag, 64'(busy), 64'd0);
    endtask

    localparam logic [31:0] PTEG_P = 32'h0010_4980;
    localparam logic [31:0] PTEG_S = 32'h0010_B640;
    localparam logic [63:0] PTE_HIT1 = 64'h8000_9180_00AB_C002;
`ifdef MMU_PTW_RC_UPDATE_EN
    localparam int HIT_LAT = 7;
`else
    localparam int HIT_LAT = 5;
`endif

    initial begin
        reset = 1'b0; req = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
        req_ea = 32'h0000_5000; req_vsid = 24'h000123; req_ks = 1'b1; req_kp = 1'b0;
        sdr1 = 32'h0010_0000;
        clear_logs();
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_mem_req", 64'(mem_req), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("rst_flags", 64'({done, fault, tlb_load}), 64'd0);
        check_val("rst_tlb_pa", 64'(tlb_new_pa), 64'd0);
        reset = 1'b1;

        // Primary hit, slot 0
        mem.delete();
        mem[PTEG_P] = PTE_HIT1;
        clear_logs();
        start_walk(1'b0);
        wait_idle("t1_idle");
        check_val("t1_reads", 64'(rd_log.size()), 64'd1);
        check_val("t1_addr0", 64'(rd_at(0)), 64'(PTEG_P));
        check_val("t1_loads", 64'(load_cnt), 64'd1);
        check_val("t1_done", 64'(done_cnt), 64'd1);
        check_val("t1_fault", 64'(fault_cnt), 64'd0);
        check_val("t1_ea", 64'(cap_ea), 64'h0000_5000);
        check_val("t1_pa", 64'(cap_pa), 64'h00AB_C000);
        check_val("t1_pp", 64'(cap_pp), 64'd2);
        check_val("t1_kskp", 64'({cap_ks, cap_kp}), 64'b10);
        check_val("t1_cacheable", 64'(cap_cach), 64'd1);
        check_val("t1_latency", 64'(load_cyc - start_cyc), 64'(HIT_LAT));

        // Primary miss, secondary hit in slot 3; a later duplicate in slot 5 is never read
        mem.delete();
        mem[PTEG_S + 32'd24] = 64'h8000_91C0_0012_3022;
        mem[PTEG_S + 32'd40] = 64'h8000_91C0_00FF_F002;
        clear_logs();
        start_walk(1'b0);
        wait_idle("t2_idle");
        check_val("t2_reads", 64'(rd_log.size()), 64'd12);
        check_val("t2_addr0", 64'(rd_at(0)), 64'h0010_4980);
        check_val("t2_addr7", 64'(rd_at(7)), 64'h0010_49B8);
        check_val("t2_addr8", 64'(rd_at(8)), 64'h0010_B640);
        check_val("t2_addr11", 64'(rd_at(11)), 64'h0010_B658);
        check_val("t2_loads", 64'(load_cnt), 64'd1);
        check_val("t2_pa", 64'(cap_pa), 64'h0012_3000);
        check_val("t2_cacheable", 64'(cap_cach), 64'd0);

        // Full miss
        mem.delete();
        clear_logs();
        start_walk(1'b0);
        wait_idle("t3_idle");
        check_val("t3_reads", 64'(rd_log.size()), 64'd16);
        check_val("t3_addr15", 64'(rd_at(15)), 64'h0010_B678);
        check_val("t3_fault", 64'(fault_cnt), 64'd1);
        check_val("t3_loads", 64'(load_cnt), 64'd0);
        check_val("t3_done", 64'(done_cnt), 64'd0);
        check_val("t3_busy_after", 64'(busy_after_fault), 64'd0);

        // Abort while waiting for a slow read that would have hit
        mem.delete();
        mem[PTEG_P] = PTE_HIT1;
        lat = 6;
        clear_logs();
        start_walk(1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_val("t4_in_wait", 64'(mem_req), 64'd1);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        wait_idle("t4_idle");
        check_val("t4_reads", 64'(rd_log.size()), 64'd1);
        check_val("t4_silent", 64'({load_cnt[3:0], done_cnt[3:0], fault_cnt[3:0]}), 64'd0);
        // Following walk starts normally even with abort raised alongside req in IDLE
        lat = 1;
        clear_logs();
        start_walk(1'b1);
        wait_idle("t4b_idle");
        check_val("t4b_loads", 64'(load_cnt), 64'd1);
        check_val("t4b_pa", 64'(cap_pa), 64'h00AB_C000);

        // Reset while checking slot 5 of the primary PTEG
        mem.delete();
        clear_logs();
        start_walk(1'b0);
        for (int k = 0; k < 100; k++) begin
            if (rd_log.size() >= 6) break;
            @(negedge clk); #1;
        end
        check_val("t5_reads_before", 64'(rd_log.size()), 64'd6);
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_mem", 64'({mem_req, mem_addr}), 64'd0);
        check_val("t5_flags", 64'({done, fault, tlb_load}), 64'd0);
        check_val("t5_tlb_pa", 64'(tlb_new_pa), 64'd0);
        reset = 1'b1;
        mem[PTEG_P] = PTE_HIT1;
        clear_logs();
        start_walk(1'b0);
        wait_idle("t5b_idle");
        check_val("t5b_reads", 64'(rd_log.size()), 64'd1);
        check_val("t5b_addr0", 64'(rd_at(0)), 64'(PTEG_P));
        check_val("t5b_loads", 64'(load_cnt), 64'd1);

`ifdef MMU_PTW_RC_UPDATE_EN
        // R bit set on a hit with R=0; no write when R is already set
        mem.delete();
        mem[PTEG_P] = PTE_HIT1;
        clear_logs();
        start_walk(1'b0);
        wait_idle("t6_idle");
        check_val("t6_writes", 64'(wr_addr_log.size()), 64'd1);
        check_val("t6_waddr", 64'((wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hDEAD_BEEF), 64'(PTEG_P));
        check_val("t6_wdata", (wr_data_log.size() > 0) ? wr_data_log[0] : 64'd0, 64'h8000_9180_00AB_C102);
        check_val("t6_order", 64'(wr_cyc < load_cyc), 64'd1);
        check_val("t6_loads", 64'(load_cnt), 64'd1);
        mem[PTEG_P] = 64'h8000_9180_00AB_C102;
        clear_logs();
        start_walk(1'b0);
        wait_idle("t6b_idle");
        check_val("t6b_writes", 64'(wr_addr_log.size()), 64'd0);
        check_val("t6b_loads", 64'(load_cnt), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
